// File: rtl/uart_mem_loader_if.sv
// Memory write port driven by the UART loader; muxed into the CPU memory
// write port while the loader holds the CPU.
interface uart_mem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_mem_loader.sv
// Serial loader: receives A5 | CNT_LO | CNT_HI | 4*N data bytes | CKSUM over UART
// and writes N little-endian 32-bit words to consecutive word addresses.
module uart_mem_loader #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              in_RST,
  input  logic              rx,
  uart_mem_loader_if.master mem,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic              busy
);
  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CKSUM, S_DONE, S_ERR
  } state_e;

  logic          rx_meta_q, rx_sync_q, rx_busy_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q, rx_byte_q;
  logic          byte_valid_q, frame_err_q;
  logic [CW-1:0] rx_lim_s;

  state_e            state_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q, addr_q;
  logic [31:0]       mem_wdata_q, word_q;
  logic [7:0]        cnt_lo_q, csum_q;
  logic [15:0]       words_left_q;
  logic [1:0]        bidx_q;
  logic [TW-1:0]     to_q;
  logic              hold_q, done_q, err_q, busy_q;
  logic              active_s;

  // Bit 0 is the start bit, resampled half a bit after the falling edge is seen.
  assign rx_lim_s = (rx_bit_q == 4'd0) ? CW'(HALF - 1) : CW'(DIV - 1);
  assign active_s = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CKSUM);

  // RX engine: synchroniser, start detect, mid-bit sampling, byte/framing-error pulses
  always_ff @(posedge clk) begin
    if (in_RST) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_busy_q    <= 1'b0;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 4'd0;
      rx_shift_q   <= 8'h00;
      rx_byte_q    <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_sync_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= '0;
          rx_bit_q  <= 4'd0;
        end
      end else if (rx_cnt_q != rx_lim_s) begin
        rx_cnt_q <= rx_cnt_q + CW'(1);
      end else begin
        rx_cnt_q <= '0;
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          if (rx_sync_q) rx_busy_q <= 1'b0;
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          if (rx_sync_q) begin
            byte_valid_q <= 1'b1;
            rx_byte_q    <= rx_shift_q;
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
        end
      end
    end
  end

  // Frame FSM with registered write port and status outputs
  always_ff @(posedge clk) begin
    if (in_RST) begin
      state_q      <= S_IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      addr_q       <= '0;
      word_q       <= 32'h0;
      cnt_lo_q     <= 8'h00;
      csum_q       <= 8'h00;
      words_left_q <= 16'h0;
      bidx_q       <= 2'd0;
      to_q         <= '0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (active_s && !byte_valid_q) to_q <= to_q + TW'(1);
      else                           to_q <= '0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (byte_valid_q && (rx_byte_q == SYNC_BYTE)) begin
            state_q <= S_CNT_LO;
            busy_q  <= 1'b1;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            csum_q  <= 8'h00;
            bidx_q  <= 2'd0;
          end
        end
        S_CNT_LO: begin
          if (byte_valid_q) begin
            cnt_lo_q <= rx_byte_q;
            csum_q   <= csum_q ^ rx_byte_q;
            state_q  <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (byte_valid_q) begin
            csum_q       <= csum_q ^ rx_byte_q;
            words_left_q <= {rx_byte_q, cnt_lo_q};
            if ({rx_byte_q, cnt_lo_q} == 16'h0) begin
              state_q <= S_CKSUM;
            end else if ({1'b0, rx_byte_q, cnt_lo_q} > MAX_WORDS) begin
              state_q <= S_ERR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (byte_valid_q) begin
            csum_q <= csum_q ^ rx_byte_q;
            word_q <= {rx_byte_q, word_q[31:8]};
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              mem_we_q     <= 1'b1;
              mem_addr_q   <= addr_q;
              mem_wdata_q  <= {rx_byte_q, word_q[31:8]};
              addr_q       <= addr_q + ADDR_W'(1);
              words_left_q <= words_left_q - 16'd1;
              if (words_left_q == 16'd1) state_q <= S_CKSUM;
            end
          end
        end
        S_CKSUM: begin
          if (byte_valid_q) begin
            busy_q <= 1'b0;
            if (rx_byte_q == csum_q) begin
              state_q <= S_DONE;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Abort overrides whatever the state did this cycle; hold stays 1.
      if (active_s && (frame_err_q || (!byte_valid_q && (to_q == TW'(TIMEOUT_CYC))))) begin
        state_q <= S_ERR;
        busy_q  <= 1'b0;
        hold_q  <= 1'b1;
        err_q   <= 1'b1;
      end
    end
  end

  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign cpu_hold      = hold_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomised frame-level bench for uart_mem_loader: expected writes and status
// are derived per frame from the frame contents.
module tb_uart_mem_loader;
  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;
  localparam int AW       = 4;
  localparam int TOUT     = 400;
  localparam int MAXW     = 2 ** AW;

  logic clk, in_RST, rx;
  logic cpu_hold, load_done, load_err, busy;
  int   errors, checks;

  logic [AW+31:0] wr_q[$];
  logic [31:0]    preset_q[$];
  logic [31:0]    words_q[$];

  uart_mem_loader_if #(.ADDR_W(AW)) bus ();

  uart_mem_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(AW), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk), .in_RST(in_RST), .rx(rx), .mem(bus.master),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write strobe seen on the memory port.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
    if (stop) begin
      rx = 1'b1;
      tick(DIV);
    end else begin
      rx = 1'b0;
      tick(HALF + 4);
      rx = 1'b1;
      tick(DIV - HALF - 4);
    end
    tick($urandom_range(1, 20));
  endtask

  task automatic check_status(input string tag, input logic ok);
    check({tag, "/done"}, 64'(load_done), 64'(ok));
    check({tag, "/err"},  64'(load_err),  64'(!ok));
    check({tag, "/hold"}, 64'(cpu_hold),  64'(!ok));
    check({tag, "/busy"}, 64'(busy),      64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "/we"},    64'(bus.mem_we),    64'd0);
    check({tag, "/addr"},  64'(bus.mem_addr),  64'd0);
    check({tag, "/wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "/hold"},  64'(cpu_hold),      64'd0);
    check({tag, "/done"},  64'(load_done),     64'd0);
    check({tag, "/err"},   64'(load_err),      64'd0);
    check({tag, "/busy"},  64'(busy),          64'd0);
  endtask

  // Sends one frame (bad_at = data-byte index sent with a bad stop bit, -1 for none)
  // and checks the resulting writes and status against the frame rules.
  task automatic run_frame(input int n, input logic [7:0] flip, input int bad_at, input string tag);
    logic [15:0] nn;
    logic [7:0]  ck, b;
    logic [31:0] w;
    logic        aborted;
    int          exp_w;
    logic        ok;
    wr_q.delete();
    words_q.delete();
    nn      = 16'(n);
    aborted = 1'b0;
    send_byte(8'hA5, 1'b1);
    send_byte(nn[7:0], 1'b1);
    send_byte(nn[15:8], 1'b1);
    ck = nn[7:0] ^ nn[15:8];
    if (n <= MAXW) begin
      for (int wi = 0; wi < n && !aborted; wi++) begin
        w = (wi < preset_q.size()) ? preset_q[wi] : $urandom;
        words_q.push_back(w);
        for (int k = 0; k < 4 && !aborted; k++) begin
          b = w[8*k +: 8];
          if (4 * wi + k == bad_at) begin
            send_byte(b, 1'b0);
            aborted = 1'b1;
          end else begin
            send_byte(b, 1'b1);
            ck = ck ^ b;
          end
        end
      end
      if (!aborted) send_byte(ck ^ flip, 1'b1);
    end
    tick(2 * DIV);
    exp_w = (n > MAXW) ? 0 : (aborted ? bad_at / 4 : n);
    ok    = (n <= MAXW) && !aborted && (flip == 8'h00);
    check({tag, "/nwr"}, 64'(wr_q.size()), 64'(exp_w));
    for (int i = 0; i < exp_w && i < wr_q.size(); i++)
      check({tag, "/wr"}, 64'(wr_q[i]), 64'({AW'(i), words_q[i]}));
    check_status(tag, ok);
    preset_q.delete();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rx     = 1'b1;
    in_RST = 1'b1;
    tick(3);
    check_idle_outputs("reset");
    in_RST = 1'b0;
    tick(2);

    preset_q = '{32'h12345678, 32'hDEADBEEF};
    run_frame(2, 8'h00, -1, "good2");
    preset_q = '{32'h12345678, 32'hDEADBEEF};
    run_frame(2, 8'h01, -1, "badck");
    run_frame(0, 8'h00, -1, "n0");
    run_frame(2, 8'h00, 1, "stop0");
    run_frame(3, 8'h00, -1, "recover");
    run_frame(2, 8'h00, $urandom_range(4, 7), "stop0b");

    // Stall after CNT_HI until the timeout fires.
    wr_q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(100);
    check("tout/busy_pre", 64'(busy), 64'd1);
    tick(TOUT);
    check("tout/err",  64'(load_err), 64'd1);
    check("tout/hold", 64'(cpu_hold), 64'd1);
    check("tout/busy", 64'(busy),     64'd0);
    check("tout/nwr",  64'(wr_q.size()), 64'd0);

    // One-clock glitch on an idle line after reset.
    in_RST = 1'b1;
    tick(1);
    in_RST = 1'b0;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(3 * DIV);
    check_idle_outputs("glitch");

    // Reset in the middle of a frame's data.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("midrst/busy_pre", 64'(busy), 64'd1);
    in_RST = 1'b1;
    tick(1);
    check_idle_outputs("midrst");
    in_RST = 1'b0;
    tick(2);
    run_frame(2, 8'h00, -1, "after_rst");

    run_frame(MAXW + 1, 8'h00, -1, "nover");
    run_frame(MAXW, 8'h00, -1, "nmax");
    for (int r = 0; r < 4; r++)
      run_frame($urandom_range(1, 4),
                ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                -1, "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
